// File: rtl/conv1x1_psum_accum_quant.sv
// Accumulates NUM_GROUP 4-channel psum beats per pixel, then bias + rounding shift + saturation.
// Build option: define CONV1X1_QUANT_RELU_EN to clamp negative results to zero (ReLU).
`ifndef BITWIDTH
`define BITWIDTH 8
`endif
`ifndef N
`define N 4
`endif

module conv1x1_psum_accum_quant #(
  parameter int BW_IN     = 2*`BITWIDTH + $clog2(4/`N) + 2,
  parameter int NUM_GROUP = 4,
  parameter int BW_ACC    = BW_IN + $clog2(NUM_GROUP) + 1,
  parameter int BW_BIAS   = BW_ACC,
  parameter int BW_SHIFT  = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [4*BW_IN-1:0]               in_psum,
  input  logic [4*BW_BIAS-1:0]             bias,
  input  logic [BW_SHIFT-1:0]              shift,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [4*`BITWIDTH-1:0]           out_data,
  output logic [$clog2(NUM_GROUP+1)-1:0]   grp_cnt
);

  localparam int BW = `BITWIDTH;
  localparam int GW = $clog2(NUM_GROUP+1);
  localparam logic signed [BW_ACC:0] Q_MAX = (BW_ACC+1)'((2**(BW-1)) - 1);
`ifdef CONV1X1_QUANT_RELU_EN
  localparam logic signed [BW_ACC:0] Q_MIN = '0;
`else
  localparam logic signed [BW_ACC:0] Q_MIN = -((BW_ACC+1)'(2**(BW-1)));
`endif

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;

  logic                     accept;
  logic                     final_beat;
  logic signed [BW_ACC-1:0] acc [4];
  logic [4*BW-1:0]          quant_word;

  // One extra bit so adding the rounding constant can never overflow.
  function automatic logic [BW-1:0] requant(input logic signed [BW_ACC-1:0] s,
                                            input logic [BW_SHIFT-1:0] sh);
    logic signed [BW_ACC:0] rnd;
    logic signed [BW_ACC:0] t;
    rnd = '0;
    if (sh != '0) rnd = (BW_ACC+1)'(1) << (sh - BW_SHIFT'(1));
    t = ((BW_ACC+1)'(s) + rnd) >>> sh;
    if (t > Q_MAX)      return Q_MAX[BW-1:0];
    else if (t < Q_MIN) return Q_MIN[BW-1:0];
    else                return t[BW-1:0];
  endfunction

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) || out_ready;
  end

  assign accept     = in_valid && in_ready;
  assign final_beat = accept && (grp_cnt == GW'(NUM_GROUP-1));

  always_comb begin
    quant_word = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      quant_word[(3-c)*BW +: BW] = requant(
        acc[c] + BW_ACC'($signed(in_psum[(3-c)*BW_IN +: BW_IN]))
               + BW_ACC'($signed(bias[(3-c)*BW_BIAS +: BW_BIAS])), shift);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < 4; c++) acc[c] <= '0;
      grp_cnt <= '0;
    end else if (accept) begin
      if (final_beat) begin
        for (int unsigned c = 0; c < 4; c++) acc[c] <= '0;
        grp_cnt <= '0;
      end else begin
        for (int unsigned c = 0; c < 4; c++)
          acc[c] <= acc[c] + BW_ACC'($signed(in_psum[(3-c)*BW_IN +: BW_IN]));
        grp_cnt <= grp_cnt + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          out_data <= '0;
    else if (final_beat) out_data <= quant_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // A final beat while FULL implies out_ready, so the old word leaves as the new one lands.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (final_beat) state_nxt = FULL;
      FULL:    if (out_ready && !final_beat) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

endmodule
